// File: rtl/clk_switch_ctrl_if.sv
// Request handshake between a clock-switch requester and clk_switch_ctrl.
// The requester holds req_valid until it sees req_ready; done/err report the outcome.
interface clk_switch_ctrl_if;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic done;
  logic err;

  modport master (output req_valid, req_sel, input  req_ready, done, err);
  modport slave  (input  req_valid, req_sel, output req_ready, done, err);
endinterface

// File: rtl/clk_switch_ctrl.sv
// Sequencer for a glitch-free two-input clock mux: watches both source heartbeats,
// steps the mux select and pulses the outgoing side's reset when that clock is dead.
module clk_switch_ctrl #(
  parameter int WD_CYCLES     = 256,
  parameter int SETTLE_CYCLES = 64,
  parameter int FORCE_CYCLES  = 8,
  parameter bit INIT_SEL      = 1'b0
) (
  input  logic               clk,
  input  logic               srst_n,
  clk_switch_ctrl_if.slave   req,
  input  logic               hb0,
  input  logic               hb1,
  output logic               mux_sel,
  output logic               mux_arst0,
  output logic               mux_arst1,
  output logic               alive0,
  output logic               alive1,
  output logic               cur_sel
);

  localparam int TMAX = (WD_CYCLES > SETTLE_CYCLES) ? WD_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int WW   = $clog2(WD_CYCLES + 1);

  localparam logic [WW-1:0] WD_MAX      = WW'(WD_CYCLES);
  localparam logic [TW-1:0] WD_LAST     = TW'(WD_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] FORCE_LAST  = TW'(FORCE_CYCLES - 1);
  localparam logic [TW-1:0] INIT_LAST   = TW'(FORCE_CYCLES);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CHECK,
    ST_SWITCH,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Heartbeat watchdogs
  // ---------------------------------------------------------------------------
  logic [1:0]    hb_s1, hb_s2, hb_s3;
  logic [1:0]    hb_edge;
  logic [WW-1:0] wd_cnt [2];
  logic [1:0]    alive_q;

  assign hb_edge = hb_s2 ^ hb_s3;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      hb_s1   <= '0;
      hb_s2   <= '0;
      hb_s3   <= '0;
      alive_q <= '0;
      // NOTE: the watchdog array is two counters, so it is reset like ordinary flops;
      // starting saturated keeps both sources "dead" until a real heartbeat arrives.
      for (int i = 0; i < 2; i++) wd_cnt[i] <= WD_MAX;
    end else begin
      hb_s1 <= {hb1, hb0};
      hb_s2 <= hb_s1;
      hb_s3 <= hb_s2;
      for (int i = 0; i < 2; i++) begin
        if (hb_edge[i])               wd_cnt[i] <= '0;
        else if (wd_cnt[i] != WD_MAX) wd_cnt[i] <= wd_cnt[i] + 1'b1;
        alive_q[i] <= (wd_cnt[i] < WD_MAX);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Switch sequencer
  // ---------------------------------------------------------------------------
  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          target, target_nx;
  logic          sel_q, sel_nx;
  logic          cur_q, cur_nx;
  logic [1:0]    arst_q, arst_nx;
  logic          err_q, err_nx;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state  <= ST_INIT;
      timer  <= '0;
      target <= INIT_SEL;
      sel_q  <= INIT_SEL;
      cur_q  <= INIT_SEL;
      arst_q <= 2'b11;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      timer  <= timer_nx;
      target <= target_nx;
      sel_q  <= sel_nx;
      cur_q  <= cur_nx;
      arst_q <= arst_nx;
      err_q  <= err_nx;
    end
  end

  // NOTE: every value this block drives gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    target_nx = target;
    sel_nx    = sel_q;
    cur_nx    = cur_q;
    arst_nx   = arst_q;
    err_nx    = err_q;

    unique case (state)
      ST_INIT: begin
        if (timer == INIT_LAST) begin
          arst_nx  = 2'b00;
          state_nx = ST_IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end

      ST_IDLE: begin
        if (req.req_valid) begin
          if (req.req_sel == cur_q) begin
            err_nx   = 1'b0;
            state_nx = ST_DONE;
          end else begin
            target_nx = req.req_sel;
            timer_nx  = '0;
            state_nx  = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (alive_q[target]) begin
          // The mux cannot release a dead outgoing clock by itself; kick that side.
          sel_nx           = target;
          timer_nx         = '0;
          arst_nx[~target] = ~alive_q[~target];
          state_nx         = ST_SWITCH;
        end else if (timer == WD_LAST) begin
          err_nx   = 1'b1;
          state_nx = ST_DONE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end

      ST_SWITCH: begin
        if (timer == FORCE_LAST) arst_nx = 2'b00;
        if (timer == SETTLE_LAST) begin
          cur_nx   = target;
          err_nx   = ~alive_q[target];
          state_nx = ST_DONE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end

      ST_DONE: state_nx = ST_IDLE;

      default: state_nx = ST_INIT;
    endcase
  end

  assign req.req_ready = (state == ST_IDLE);
  assign req.done      = (state == ST_DONE);
  assign req.err       = (state == ST_DONE) & err_q;
  assign mux_sel       = sel_q;
  assign cur_sel       = cur_q;
  assign mux_arst0     = arst_q[0];
  assign mux_arst1     = arst_q[1];
  assign alive0        = alive_q[0];
  assign alive1        = alive_q[1];

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl: table of switch requests under different
// heartbeat conditions, plus hand-written reset and reset-during-switch sequences.
module tb_clk_switch_ctrl;

  localparam int WD     = 16;
  localparam int SETTLE = 8;
  localparam int FORCE  = 3;

  logic clk;
  logic srst_n;
  logic hb0, hb1;
  logic hb0_en, hb1_en;
  logic mux_sel, mux_arst0, mux_arst1, alive0, alive1, cur_sel;

  int n_checks = 0;
  int n_err    = 0;

  clk_switch_ctrl_if req_if ();

  clk_switch_ctrl #(
    .WD_CYCLES    (WD),
    .SETTLE_CYCLES(SETTLE),
    .FORCE_CYCLES (FORCE),
    .INIT_SEL     (1'b0)
  ) dut (
    .clk      (clk),
    .srst_n   (srst_n),
    .req      (req_if),
    .hb0      (hb0),
    .hb1      (hb1),
    .mux_sel  (mux_sel),
    .mux_arst0(mux_arst0),
    .mux_arst1(mux_arst1),
    .alive0   (alive0),
    .alive1   (alive1),
    .cur_sel  (cur_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Heartbeats toggle once per reference cycle, away from the clk edge, while enabled.
  initial begin
    hb0 = 1'b0;
    hb1 = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (hb0_en) hb0 = ~hb0;
      if (hb1_en) hb1 = ~hb1;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic sel;
    logic hb0_run;
    logic hb1_run;
    int   done_k;    // cycle (after accept cycle 0) in which done is high
    logic err;
    int   sel_k;     // cycle in which mux_sel first differs, 0 = never
    logic mux;
    logic cur;
    int   a0_cnt;
    int   a0_first;
    int   a1_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    int    wait_k, k, done_k, sel_k, a0_cnt, a0_first, a1_cnt, ready_hi;
    logic  sel0, err_at;
    tag    = $sformatf("v%0d", idx);
    hb0_en = v.hb0_run;
    hb1_en = v.hb1_run;
    repeat (40) @(posedge clk);
    #1;
    check({tag, ".alive0"}, alive0, v.hb0_run);
    check({tag, ".alive1"}, alive1, v.hb1_run);

    req_if.req_sel   = v.sel;
    req_if.req_valid = 1'b1;
    wait_k = 0;
    while (req_if.req_ready !== 1'b1 && wait_k < 20) begin
      @(posedge clk); #1;
      wait_k++;
    end
    check({tag, ".ready"}, req_if.req_ready, 1);

    sel0 = mux_sel;
    done_k = 0; sel_k = 0; a0_cnt = 0; a0_first = 0; a1_cnt = 0; ready_hi = 0;
    err_at = 1'b0;
    k = 0;
    while (done_k == 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) req_if.req_valid = 1'b0;
      if (sel_k == 0 && mux_sel !== sel0) sel_k = k;
      if (mux_arst0) begin
        a0_cnt++;
        if (a0_first == 0) a0_first = k;
      end
      if (mux_arst1) a1_cnt++;
      if (req_if.req_ready) ready_hi++;
      if (req_if.done) begin
        done_k = k;
        err_at = req_if.err;
      end
    end
    check({tag, ".done_cycle"}, done_k, v.done_k);
    check({tag, ".err"}, err_at, v.err);
    check({tag, ".mux_sel_cycle"}, sel_k, v.sel_k);
    check({tag, ".mux_sel"}, mux_sel, v.mux);
    check({tag, ".cur_sel"}, cur_sel, v.cur);
    check({tag, ".arst0_cycles"}, a0_cnt, v.a0_cnt);
    check({tag, ".arst0_first"}, a0_first, v.a0_first);
    check({tag, ".arst1_cycles"}, a1_cnt, v.a1_cnt);
    check({tag, ".ready_busy"}, ready_hi, 0);
    @(posedge clk); #1;
    check({tag, ".done_width"}, req_if.done, 0);
    check({tag, ".ready_after"}, req_if.req_ready, 1);
  endtask

  initial begin
    int k;
    int done_k;
    logic err_at;

    //          sel   hb0   hb1   done err  selk mux  cur  a0n a0f a1n
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1,   1'b0, 0,  1'b0, 1'b0, 0, 0, 0};  // same sel
    vecs[1] = '{1'b1, 1'b1, 1'b1, 10,  1'b0, 2,  1'b1, 1'b1, 0, 0, 0};  // switch to in1
    vecs[2] = '{1'b0, 1'b1, 1'b1, 10,  1'b0, 2,  1'b0, 1'b0, 0, 0, 0};  // back to in0
    vecs[3] = '{1'b1, 1'b1, 1'b0, 17,  1'b1, 0,  1'b0, 1'b0, 0, 0, 0};  // target dead
    vecs[4] = '{1'b1, 1'b0, 1'b1, 10,  1'b0, 2,  1'b1, 1'b1, 3, 2, 0};  // outgoing dead
    vecs[5] = '{1'b0, 1'b1, 1'b1, 10,  1'b0, 2,  1'b0, 1'b0, 0, 0, 0};  // recover to in0

    srst_n           = 1'b0;
    hb0_en           = 1'b0;
    hb1_en           = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_sel   = 1'b0;

    // Reset values, INIT reset hold, heartbeat rise time.
    repeat (3) @(posedge clk);
    #1;
    check("rst.mux_sel", mux_sel, 0);
    check("rst.cur_sel", cur_sel, 0);
    check("rst.arst0", mux_arst0, 1);
    check("rst.arst1", mux_arst1, 1);
    check("rst.ready", req_if.req_ready, 0);
    check("rst.done", req_if.done, 0);
    check("rst.err", req_if.err, 0);
    check("rst.alive0", alive0, 0);
    check("rst.alive1", alive1, 0);
    srst_n = 1'b1;
    for (int i = 1; i <= FORCE; i++) begin
      @(posedge clk); #1;
      check($sformatf("init%0d.arst0", i), mux_arst0, 1);
      check($sformatf("init%0d.arst1", i), mux_arst1, 1);
      check($sformatf("init%0d.ready", i), req_if.req_ready, 0);
    end
    @(posedge clk); #1;
    check("idle.arst0", mux_arst0, 0);
    check("idle.arst1", mux_arst1, 0);
    check("idle.ready", req_if.req_ready, 1);
    hb0_en = 1'b1;
    hb1_en = 1'b1;
    k = 0;
    while (!(alive0 && alive1) && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("alive_rise_cycles", k, 4);
    check("idle.ready_hold", req_if.req_ready, 1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset during SWITCH with the request held across it.
    hb0_en = 1'b1;
    hb1_en = 1'b1;
    req_if.req_sel   = 1'b1;
    req_if.req_valid = 1'b1;
    k = 0;
    while (req_if.req_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("sw_rst.pre_mux_sel", mux_sel, 1);
    srst_n = 1'b0;
    @(posedge clk); #1;
    check("sw_rst.mux_sel", mux_sel, 0);
    check("sw_rst.arst0", mux_arst0, 1);
    check("sw_rst.arst1", mux_arst1, 1);
    check("sw_rst.done", req_if.done, 0);
    check("sw_rst.ready", req_if.req_ready, 0);
    check("sw_rst.cur_sel", cur_sel, 0);
    @(posedge clk); #1;
    check("sw_rst.done2", req_if.done, 0);
    srst_n = 1'b1;
    for (int i = 1; i <= FORCE; i++) begin
      @(posedge clk); #1;
      check($sformatf("sw_init%0d.ready", i), req_if.req_ready, 0);
      check($sformatf("sw_init%0d.done", i), req_if.done, 0);
    end
    @(posedge clk); #1;
    check("sw_idle.ready", req_if.req_ready, 1);
    done_k = 0;
    err_at = 1'b0;
    k = 0;
    while (done_k == 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) req_if.req_valid = 1'b0;
      if (req_if.done) begin
        done_k = k;
        err_at = req_if.err;
      end
    end
    check("sw_after.done_cycle", done_k, SETTLE + 2);
    check("sw_after.err", err_at, 0);
    check("sw_after.mux_sel", mux_sel, 1);
    check("sw_after.cur_sel", cur_sel, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Sequencer for the glitch-free two-input clock mux, running on a free-running reference clock.
- Accepts switch requests over a valid/ready handshake and monitors both source clocks via heartbeat toggles.
- Drives the mux select and per-side asynchronous resets, recovering the mux when the outgoing clock is dead (mux cannot release a dead side on its own).
- Reports completion and error per request.

Parameters:
- WD_CYCLES, 256: clk cycles without a heartbeat edge before a source is declared dead; also the CHECK timeout.
- SETTLE_CYCLES, 64: cycles mux_sel is held in SWITCH before completion.
- FORCE_CYCLES, 8: cycles the outgoing side's reset is pulsed when that source is dead. Must be < SETTLE_CYCLES.
- INIT_SEL, 0: mux_sel / cur_sel value at reset.

Ports:
- clk, in, 1: reference clock; all logic is in this domain.
- srst_n, in, 1: synchronous reset, active-low.
- req_valid, in, 1: switch request valid.
- req_sel, in, 1: requested source (0 = in0, 1 = in1).
- req_ready, out, 1: request accepted when req_valid & req_ready.
- hb0, in, 1: asynchronous toggle heartbeat from the in0 clock domain.
- hb1, in, 1: asynchronous toggle heartbeat from the in1 clock domain.
- mux_sel, out, 1: mux select.
- mux_arst0, out, 1: mux in0-side reset (active-high).
- mux_arst1, out, 1: mux in1-side reset (active-high).
- alive0, out, 1: in0 heartbeat seen within WD_CYCLES.
- alive1, out, 1: in1 heartbeat seen within WD_CYCLES.
- cur_sel, out, 1: last committed selection.
- done, out, 1: one-cycle completion pulse.
- err, out, 1: qualified by done; 1 = request failed or target lost.

Behaviour:
- Reset values (srst_n low at a clk edge):
  - state = INIT; mux_sel = cur_sel = INIT_SEL.
  - mux_arst0 = mux_arst1 = 1; req_ready = done = err = 0.
  - Watchdog counters = WD_CYCLES, so alive0 = alive1 = 0.
- srst_n low mid-operation aborts any request immediately, with no done pulse.
- Heartbeat path:
  - Each hbX passes through 2 sync flops plus 1 history flop; edge = stage2 XOR stage3.
  - On edge the counter clears to 0; otherwise it increments, saturating at WD_CYCLES.
  - aliveX = (counter < WD_CYCLES), registered.
- INIT: hold both mux resets for FORCE_CYCLES cycles, then deassert both and go to IDLE.
- IDLE:
  - req_ready = 1; it is 0 in every other state. Requests are never dropped; the requester holds req_valid.
  - On accept with req_sel == cur_sel: go to DONE, err = 0, no mux activity.
  - On accept with req_sel != cur_sel: latch target = req_sel and go to CHECK with timer = 0.
- CHECK:
  - If alive[target]: go to SWITCH; mux_sel <= target; timer <= 0; mux_arst[~target] <= ~alive[~target], sampled once here.
  - Else timer++; when timer == WD_CYCLES-1, go to DONE with err = 1. mux_sel and cur_sel are unchanged.
- SWITCH:
  - Lasts exactly SETTLE_CYCLES cycles.
  - A forced outgoing-side reset stays high for exactly FORCE_CYCLES cycles, then deasserts.
  - On the last cycle: cur_sel <= target; go to DONE with err = ~alive[target].
  - The selection is committed even on err; a target lost mid-SWITCH is reported, not reverted.
  - An outgoing clock that dies after the CHECK sample does not trigger a force.
- DONE: done = 1 for exactly one cycle, err valid in the same cycle, then IDLE.
- Latency from the accept edge E (target alive):
  - mux_sel changes at E+2.
  - done is high in the cycle after edge E+2+SETTLE_CYCLES.
- Latency, same-sel request: done in the cycle after E+1.
- Latency, timeout: done in the cycle after E+1+WD_CYCLES.
- Invariants:
  - Never assert the reset of the currently selected, alive side.
  - Never assert both mux resets outside INIT.

Test Plan (WD_CYCLES=16, SETTLE_CYCLES=8, FORCE_CYCLES=3, INIT_SEL=0):
- Reset, then both heartbeats toggling: mux_arst0/1 = 1 for 3 cycles after reset release, then 0; alive0/1 rise within 4 cycles of the first hb edge; req_ready = 1 in IDLE.
- Both alive, request sel=1: mux_sel = 1 at accept+2; no arst pulses; done = 1 with err = 0 at accept+10; cur_sel = 1; req_ready low throughout.
- Request sel=0 with cur_sel=0: done pulse at accept+1, err = 0; mux_sel, mux_arst0 and mux_arst1 untouched.
- hb1 stopped for more than 16 cycles, request sel=1: alive1 = 0; done with err = 1 at accept+17; mux_sel stays 0.
- cur_sel=0 with hb0 stopped, hb1 alive, request sel=1: mux_sel = 1; mux_arst0 high for exactly 3 cycles starting at accept+2; mux_arst1 stays 0; done with err = 0.
- srst_n low during SWITCH: next edge gives mux_sel = 0, both arsts = 1, no done pulse; a request held across reset is accepted only after INIT completes.
